// File: rtl/ctrl_pipe_seq.sv
// ctrl_pipe_seq
//   Control-signal pipeline for the pipelined core. The decoded control
//   bundle travels from decode through NSTAGES downstream stages, and each
//   stage carries a valid bit. A stall inserts a bubble into stage 1. A
//   redirect squashes the youngest stages. A freeze holds every stage. The
//   block also produces a multi-cycle fetch-kill window and counts retired
//   instructions.
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        synchronous, active-high reset
//   d_ctrl_i       control bundle from decode
//   d_valid_i      decode holds a real instruction
//   stall_i        load-use hazard: a bubble enters stage 1
//   freeze_i       hold every stage register
//   redirect_i     taken control transfer resolved in decode
//   stage_ctrl_o   bundle of stage k in bits [k*CTRL_W-1 -: CTRL_W], k=1..NSTAGES
//   stage_valid_o  valid bit of stage k in bit k-1
//   kill_f_o       squash the fetch/decode slot
//   retire_cnt_o   number of valid instructions leaving the last stage (wraps)
module ctrl_pipe_seq #(
   parameter int                NSTAGES     = 3,
   parameter int                CTRL_W      = 8,
   parameter logic [CTRL_W-1:0] SIDE_MASK   = 8'h03,
   parameter int                FLUSH_DEPTH = 1,
   parameter int                KILL_CYCLES = 1,
   parameter int                RETIRE_W    = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [CTRL_W-1:0]         d_ctrl_i,
   input  logic                      d_valid_i,
   input  logic                      stall_i,
   input  logic                      freeze_i,
   input  logic                      redirect_i,
   output logic [NSTAGES*CTRL_W-1:0] stage_ctrl_o,
   output logic [NSTAGES-1:0]        stage_valid_o,
   output logic                      kill_f_o,
   output logic [RETIRE_W-1:0]       retire_cnt_o
);

   localparam int KCNT_W = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;

   // Build the mask of the stages that a redirect squashes (stages 1..FLUSH_DEPTH).
   function automatic logic [NSTAGES-1:0] flush_mask_f();
      logic [NSTAGES-1:0] m;
      for (int k = 0; k < NSTAGES; k++) begin
         if (k < FLUSH_DEPTH) begin
            m[k] = 1'b1;
         end else begin
            m[k] = 1'b0;
         end
      end
      return m;
   endfunction

   localparam logic [NSTAGES-1:0] FLUSH_MASK = flush_mask_f();

   logic [CTRL_W-1:0]   ctrl_q [NSTAGES];
   logic [CTRL_W-1:0]   ctrl_d [NSTAGES];
   logic [NSTAGES-1:0]  valid_q, valid_d, valid_adv_s;
   logic [KCNT_W-1:0]   kcnt_q, kcnt_d;
   logic [RETIRE_W-1:0] retire_q, retire_d;

   // Next stage contents: advance or hold, then apply the squash on top.
   always_comb begin
      ctrl_d      = ctrl_q;
      valid_adv_s = valid_q;
      if (!freeze_i) begin
         ctrl_d[0]      = d_ctrl_i;
         valid_adv_s[0] = d_valid_i & ~stall_i & ~redirect_i;
         for (int k = 1; k < NSTAGES; k++) begin
            ctrl_d[k]      = ctrl_q[k-1];
            valid_adv_s[k] = valid_q[k-1];
         end
      end else begin
         ctrl_d      = ctrl_q;
         valid_adv_s = valid_q;
      end
      // A squash is applied even under freeze, so a redirect is never lost.
      if (redirect_i) begin
         valid_d = valid_adv_s & ~FLUSH_MASK;
      end else begin
         valid_d = valid_adv_s;
      end
   end

   // Next kill counter. A redirect reloads it, otherwise it counts down to zero. Freeze does not stop it.
   always_comb begin
      kcnt_d = kcnt_q;
      if (redirect_i) begin
         kcnt_d = KCNT_W'(KILL_CYCLES - 1);
      end else if (kcnt_q != {KCNT_W{1'b0}}) begin
         kcnt_d = kcnt_q - {{(KCNT_W-1){1'b0}}, 1'b1};
      end else begin
         kcnt_d = {KCNT_W{1'b0}};
      end
   end

   // Next retire count. It increments when the last stage moves out while valid.
   always_comb begin
      retire_d = retire_q;
      if (!freeze_i && valid_q[NSTAGES-1]) begin
         retire_d = retire_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
      end else begin
         retire_d = retire_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int k = 0; k < NSTAGES; k++) begin
            ctrl_q[k] <= {CTRL_W{1'b0}};
         end
         valid_q  <= {NSTAGES{1'b0}};
         kcnt_q   <= {KCNT_W{1'b0}};
         retire_q <= {RETIRE_W{1'b0}};
      end else begin
         for (int k = 0; k < NSTAGES; k++) begin
            ctrl_q[k] <= ctrl_d[k];
         end
         valid_q  <= valid_d;
         kcnt_q   <= kcnt_d;
         retire_q <= retire_d;
      end
   end

   // Output view. Side-effect bits are hidden in invalid stages; the other bits pass unchanged.
   always_comb begin
      stage_ctrl_o = {(NSTAGES*CTRL_W){1'b0}};
      for (int k = 0; k < NSTAGES; k++) begin
         if (valid_q[k]) begin
            stage_ctrl_o[k*CTRL_W +: CTRL_W] = ctrl_q[k];
         end else begin
            stage_ctrl_o[k*CTRL_W +: CTRL_W] = ctrl_q[k] & ~SIDE_MASK;
         end
      end
      stage_valid_o = valid_q;
      retire_cnt_o  = retire_q;
      kill_f_o      = redirect_i | (kcnt_q != {KCNT_W{1'b0}});
   end

endmodule
